// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared CPU definitions for the register-file writeback path:
// default widths and the writeback source encoding.
package regfile_wb_arbiter_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 3;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_LD  = 1'b1
   } src_e;

   // One-hot decode of a register index into a scoreboard-sized mask.
   function automatic logic [2**DEF_ADDR_W-1:0] idx_mask(input logic [DEF_ADDR_W-1:0] idx);
      logic [2**DEF_ADDR_W-1:0] m;
      m = '0;
      m[idx] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: combinational grant, registered
// priority pointer that flips to the other source after every grant.
module rr_arbiter2
   import regfile_wb_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       i_reset,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);

   src_e       r_ptr;
   logic [1:0] w_gnt;

   always_comb begin
      w_gnt = 2'b00;
      if (!i_reset) begin
         if (i_req[SRC_ALU] && i_req[SRC_LD])
            w_gnt[r_ptr] = 1'b1;
         else
            w_gnt = i_req;
      end
   end

   always_ff @(posedge clk) begin
      if (i_reset)
         r_ptr <= SRC_ALU;
      else if (w_gnt[SRC_ALU])
         r_ptr <= SRC_LD;
      else if (w_gnt[SRC_LD])
         r_ptr <= SRC_ALU;
   end

   assign o_gnt = w_gnt;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: picks ALU or load result each cycle, registers the
// register-file write port, and tracks pending writes per register.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NREGS  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_wd,
   output logic              alu_ready,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_rd,
   input  logic [DATA_W-1:0] ld_wd,
   output logic              ld_ready,
   input  logic              rsv_valid,
   input  logic [ADDR_W-1:0] rsv_rd,
   output logic              we,
   output logic [ADDR_W-1:0] rd,
   output logic [DATA_W-1:0] wd,
   output logic [NREGS-1:0]  busy
);

   logic [1:0]        w_req;
   logic [1:0]        w_gnt;
   logic              r_we;
   logic [ADDR_W-1:0] r_rd;
   logic [DATA_W-1:0] r_wd;
   logic [NREGS-1:0]  r_busy;
   logic [NREGS-1:0]  w_busy_nxt;

   assign w_req[SRC_ALU] = alu_valid;
   assign w_req[SRC_LD]  = ld_valid;

   rr_arbiter2 u_arb (
      .clk     (clk),
      .i_reset (reset),
      .i_req   (w_req),
      .o_gnt   (w_gnt)
   );

   assign alu_ready = w_gnt[SRC_ALU];
   assign ld_ready  = w_gnt[SRC_LD];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_we <= 1'b0;
         r_rd <= '0;
         r_wd <= '0;
      end else begin
         r_we <= |w_gnt;
         if (w_gnt[SRC_LD]) begin
            r_rd <= ld_rd;
            r_wd <= ld_wd;
         end else if (w_gnt[SRC_ALU]) begin
            r_rd <= alu_rd;
            r_wd <= alu_wd;
         end
      end
   end

   // Clear for the write committing at this edge first, so a same-edge
   // reservation of that register leaves the bit set.
   always_comb begin
      w_busy_nxt = r_busy;
      if (r_we)
         w_busy_nxt[r_rd] = 1'b0;
      if (rsv_valid)
         w_busy_nxt[rsv_rd] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_busy <= '0;
      else
         r_busy <= w_busy_nxt;
   end

   assign we   = r_we;
   assign rd   = r_rd;
   assign wd   = r_wd;
   assign busy = r_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: behavioural model checked every
// cycle, plus literal expectations for each scenario.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid, ld_valid, rsv_valid;
   logic [2:0]  alu_rd, ld_rd, rsv_rd;
   logic [15:0] alu_wd, ld_wd;
   logic        alu_ready, ld_ready, we;
   logic [2:0]  rd;
   logic [15:0] wd;
   logic [7:0]  busy;

   int n_checks = 0;
   int n_errors = 0;

   regfile_wb_arbiter dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_ready(alu_ready),
      .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_wd(ld_wd), .ld_ready(ld_ready),
      .rsv_valid(rsv_valid), .rsv_rd(rsv_rd),
      .we(we), .rd(rd), .wd(wd), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Model state: who wins a tie next, the pending write, and the set of
   // registers with an outstanding reservation.
   bit        m_ld_first;
   bit        m_we;
   bit [2:0]  m_rd;
   bit [15:0] m_wd;
   bit        m_busy [8];
   bit        started = 0;

   function automatic bit exp_alu_gnt();
      return !reset && alu_valid && (!ld_valid || !m_ld_first);
   endfunction

   function automatic bit exp_ld_gnt();
      return !reset && ld_valid && (!alu_valid || m_ld_first);
   endfunction

   always @(posedge clk) begin
      bit ga, gl;
      ga = exp_alu_gnt();
      gl = exp_ld_gnt();
      started = 1;
      if (reset) begin
         m_ld_first = 0; m_we = 0; m_rd = 0; m_wd = 0;
         foreach (m_busy[i]) m_busy[i] = 0;
      end else begin
         if (m_we) m_busy[m_rd] = 0;
         if (rsv_valid) m_busy[rsv_rd] = 1;
         m_we = ga || gl;
         if (ga) begin m_rd = alu_rd; m_wd = alu_wd; m_ld_first = 1; end
         if (gl) begin m_rd = ld_rd;  m_wd = ld_wd;  m_ld_first = 0; end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         logic [7:0] mb;
         foreach (m_busy[i]) mb[i] = m_busy[i];
         check("model_alu_ready", {31'b0, alu_ready}, {31'b0, exp_alu_gnt()});
         check("model_ld_ready",  {31'b0, ld_ready},  {31'b0, exp_ld_gnt()});
         check("model_we", {31'b0, we}, {31'b0, m_we});
         if (m_we) begin
            check("model_rd", {29'b0, rd}, {29'b0, m_rd});
            check("model_wd", {16'b0, wd}, {16'b0, m_wd});
         end
         check("model_busy", {24'b0, busy}, {24'b0, mb});
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1; alu_valid = 0; ld_valid = 0; rsv_valid = 0;
      alu_rd = 0; ld_rd = 0; rsv_rd = 0; alu_wd = 0; ld_wd = 0;
      cyc(); cyc();
      reset = 0;
      // Idle after reset
      #1;
      check("rst_we", {31'b0, we}, 32'd0);
      check("rst_busy", {24'b0, busy}, 32'h00);
      check("rst_rd", {29'b0, rd}, 32'd0);
      check("rst_wd", {16'b0, wd}, 32'd0);
      check("idle_readies", {30'b0, alu_ready, ld_ready}, 32'd0);

      // Single ALU write
      cyc();
      alu_valid = 1; alu_rd = 3; alu_wd = 16'h1234;
      #1 check("s2_alu_ready", {31'b0, alu_ready}, 32'd1);
      cyc();
      alu_valid = 0;
      check("s2_we", {31'b0, we}, 32'd1);
      check("s2_rd", {29'b0, rd}, 32'd3);
      check("s2_wd", {16'b0, wd}, 32'h1234);
      cyc();
      check("s2_we_off", {31'b0, we}, 32'd0);

      // Both valid after reset: ALU, LD, ALU, LD
      reset = 1; cyc(); reset = 0;
      alu_valid = 1; alu_rd = 1; alu_wd = 16'hAAAA;
      ld_valid  = 1; ld_rd  = 2; ld_wd  = 16'hBBBB;
      for (int k = 0; k < 4; k++) begin
         #1 check("s3_grant", {30'b0, alu_ready, ld_ready}, (k % 2 == 0) ? 32'b10 : 32'b01);
         cyc();
         check("s3_we", {31'b0, we}, 32'd1);
         check("s3_wd", {16'b0, wd}, (k % 2 == 0) ? 32'hAAAA : 32'hBBBB);
      end
      alu_valid = 0; ld_valid = 0;
      cyc();
      check("s3_we_off", {31'b0, we}, 32'd0);

      // Reserve r5, load writes r5 two cycles later
      rsv_valid = 1; rsv_rd = 5;
      cyc();
      rsv_valid = 0;
      check("s4_busy5_set", {31'b0, busy[5]}, 32'd1);
      cyc();
      ld_valid = 1; ld_rd = 5; ld_wd = 16'h5555;
      #1 check("s4_ld_ready", {31'b0, ld_ready}, 32'd1);
      cyc();
      ld_valid = 0;
      check("s4_we_rd5", {28'b0, we, rd}, {28'b0, 1'b1, 3'd5});
      check("s4_busy5_pending", {31'b0, busy[5]}, 32'd1);
      cyc();
      check("s4_busy5_clear", {31'b0, busy[5]}, 32'd0);

      // Reserve r2 on the edge that commits a write to r2; re-reserve; write r0
      alu_valid = 1; alu_rd = 2; alu_wd = 16'h2222;
      cyc();
      alu_valid = 0;
      rsv_valid = 1; rsv_rd = 2;
      cyc();
      check("s5_busy2_set_wins", {31'b0, busy[2]}, 32'd1);
      cyc();
      rsv_valid = 0;
      check("s5_busy2_rereserve", {31'b0, busy[2]}, 32'd1);
      alu_valid = 1; alu_rd = 0; alu_wd = 16'h0F0F;
      cyc();
      alu_valid = 0;
      check("s5_we_r0", {12'b0, we, rd, wd}, {12'b0, 1'b1, 3'd0, 16'h0F0F});
      cyc();
      check("s5_busy0_stays0", {31'b0, busy[0]}, 32'd0);

      // Reset while a write is in flight
      alu_valid = 1; alu_rd = 7; alu_wd = 16'h7777;
      cyc();
      alu_valid = 0;
      check("s6_we_before", {31'b0, we}, 32'd1);
      reset = 1;
      ld_valid = 1; ld_rd = 6; ld_wd = 16'h6666;
      rsv_valid = 1; rsv_rd = 4;
      #1 check("s6_ready_in_reset", {30'b0, alu_ready, ld_ready}, 32'd0);
      cyc();
      reset = 0; rsv_valid = 0;
      check("s6_we_after_reset", {31'b0, we}, 32'd0);
      check("s6_busy_after_reset", {24'b0, busy}, 32'h00);
      #1 check("s6_ld_ready_post", {31'b0, ld_ready}, 32'd1);
      cyc();
      ld_valid = 0;
      check("s6_post_write", {12'b0, we, rd, wd}, {12'b0, 1'b1, 3'd6, 16'h6666});
      cyc(); cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
